// File: rtl/uart_pkg.sv
// Constants shared by the UART RX datapath: legal word lengths and bit-order encoding.
package uart_pkg;
  localparam int UART_MIN_DATA_LEN = 5;
  localparam int UART_MAX_DATA_LEN = 9;
  localparam int BIT_ORDER_LSB     = 0;
  localparam int BIT_ORDER_MSB     = 1;
endpackage

// File: rtl/uart_rx_deser_param.sv
// Serial-to-parallel deserialiser for UART RX: assembles a runtime-length word,
// LSB- or MSB-first, and presents it on a registered P_DATA with a done strobe.
module uart_rx_deser_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = BIT_ORDER_LSB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sampled_bit,
  input  logic                  deser_en,
  input  logic                  deser_clr,
  input  logic [3:0]            data_len,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_done,
  output logic                  busy,
  output logic [3:0]            bit_cnt
);

  if (DATA_WIDTH < UART_MIN_DATA_LEN || DATA_WIDTH > UART_MAX_DATA_LEN) begin : g_bad_width
    $error("uart_rx_deser_param: DATA_WIDTH out of range");
  end

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] word_next;
  logic [3:0]            len_q;
  logic [3:0]            len_in;
  logic [3:0]            len_cur;
  logic [3:0]            idx;
  logic                  last_bit;

  always_comb begin
    len_in = data_len;
    if (data_len < 4'(UART_MIN_DATA_LEN) || data_len > 4'(DATA_WIDTH))
      len_in = 4'(DATA_WIDTH);
    // The first bit of a word uses the live length; later bits use the latched one.
    len_cur  = (bit_cnt == 4'd0) ? len_in : len_q;
    idx      = (MSB_FIRST == BIT_ORDER_MSB) ? (len_cur - 4'd1 - bit_cnt) : bit_cnt;
    last_bit = (bit_cnt == len_cur - 4'd1);
  end

  // Current word with the incoming bit merged in and bits above len forced low.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    assign word_next[gi] = (4'(gi) >= len_cur) ? 1'b0 :
                           (4'(gi) == idx)     ? sampled_bit : shift_q[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt   <= 4'd0;
      len_q     <= 4'd0;
      P_DATA    <= '0;
      data_done <= 1'b0;
    end else begin
      data_done <= 1'b0;
      if (deser_clr) begin
        bit_cnt <= 4'd0;
        shift_q <= '0;
      end else if (deser_en) begin
        if (bit_cnt == 4'd0)
          len_q <= len_in;
        if (last_bit) begin
          P_DATA    <= word_next;
          data_done <= 1'b1;
          bit_cnt   <= 4'd0;
          shift_q   <= '0;
        end else begin
          shift_q <= word_next;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign busy = (bit_cnt != 4'd0);

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Bench for uart_rx_deser_param: LSB-first and MSB-first instances share stimulus;
// expected words are queued by the stimulus and popped by a monitor on data_done.
module tb_uart_rx_deser_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       deser_en = 1'b0;
  logic       deser_clr = 1'b0;
  logic [3:0] data_len = 4'd8;

  logic [7:0] lsb_p_data, msb_p_data;
  logic       lsb_done, msb_done, lsb_busy, msb_busy;
  logic [3:0] lsb_cnt, msb_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lsb_last_done_cyc = -1;
  int lsb_prev_done_cyc = -1;
  logic lsb_done_d = 1'b0;
  logic msb_done_d = 1'b0;

  logic [7:0] exp_lsb[$];
  logic [7:0] exp_msb[$];

  uart_rx_deser_param #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
    .deser_clr(deser_clr), .data_len(data_len), .P_DATA(lsb_p_data),
    .data_done(lsb_done), .busy(lsb_busy), .bit_cnt(lsb_cnt)
  );

  uart_rx_deser_param #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
    .deser_clr(deser_clr), .data_len(data_len), .P_DATA(msb_p_data),
    .data_done(msb_done), .busy(msb_busy), .bit_cnt(msb_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every data_done pops one expected word per instance.
  always @(negedge clk) begin
    if (lsb_done) begin
      lsb_prev_done_cyc = lsb_last_done_cyc;
      lsb_last_done_cyc = cyc;
      if (exp_lsb.size() == 0) check("lsb_unexpected_done", {24'd0, lsb_p_data}, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp_lsb.pop_front();
        $display("lsb word 0x%02h (expect 0x%02h) at cycle %0d", lsb_p_data, e, cyc);
        check("lsb_word", {24'd0, lsb_p_data}, {24'd0, e});
      end
      if (lsb_done_d) check("lsb_done_width", 32'd2, 32'd1);
    end
    if (msb_done) begin
      if (exp_msb.size() == 0) check("msb_unexpected_done", {24'd0, msb_p_data}, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp_msb.pop_front();
        $display("msb word 0x%02h (expect 0x%02h) at cycle %0d", msb_p_data, e, cyc);
        check("msb_word", {24'd0, msb_p_data}, {24'd0, e});
      end
      if (msb_done_d) check("msb_done_width", 32'd2, 32'd1);
    end
    lsb_done_d = lsb_done;
    msb_done_d = msb_done;
  end

  // bits[i] is the i-th transmitted bit; b2b keeps deser_en high every cycle.
  task automatic send(input logic [8:0] bits, input int n, input bit b2b);
    for (int i = 0; i < n; i++) begin
      sampled_bit = bits[i];
      deser_en    = 1'b1;
      @(posedge clk); #1;
      deser_en = 1'b0;
      if (!b2b && i < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // 1: reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sampled_bit = 1'($urandom_range(0, 1));
      deser_en    = 1'($urandom_range(0, 1));
      deser_clr   = 1'($urandom_range(0, 1));
      data_len    = 4'($urandom_range(0, 15));
    end
    check("rst_lsb_pdata", {24'd0, lsb_p_data}, 32'd0);
    check("rst_msb_pdata", {24'd0, msb_p_data}, 32'd0);
    check("rst_done_busy", {30'd0, lsb_done | msb_done, lsb_busy | msb_busy}, 32'd0);
    check("rst_bit_cnt", {24'd0, lsb_cnt, msb_cnt}, 32'd0);
    deser_en = 1'b0; deser_clr = 1'b0; data_len = 4'd8;
    rst = 1'b1;
    idle(3);
    check("post_rst_pdata", {16'd0, lsb_p_data, msb_p_data}, 32'd0);
    check("post_rst_cnt", {24'd0, lsb_cnt, msb_cnt}, 32'd0);

    // 2/3: 8-bit word, bits 1,0,1,1,0,0,1,0
    exp_lsb.push_back(8'h4D); exp_msb.push_back(8'hB2);
    send(9'h04D, 8, 1'b0);
    check("w1_done_latency", {31'd0, lsb_done}, 32'd1);
    idle(1);
    check("w1_done_one_cycle", {31'd0, lsb_done}, 32'd0);
    check("w1_busy_low", {30'd0, lsb_busy, msb_busy}, 32'd0);

    // 4: 5-bit word 1,1,0,1,0
    data_len = 4'd5;
    exp_lsb.push_back(8'h0B); exp_msb.push_back(8'h1A);
    send(9'h00B, 5, 1'b0);
    idle(1);
    // mid-word length change must not stretch the word: bits 0,1 | len=7 | 1,1,1
    exp_lsb.push_back(8'h1E); exp_msb.push_back(8'h0F);
    send(9'h002, 2, 1'b0);
    data_len = 4'd7;
    send(9'h007, 3, 1'b0);
    check("len_latch_cnt", {24'd0, lsb_cnt, msb_cnt}, 32'd0);
    idle(1);
    data_len = 4'd8;

    // 5: partial word, clear with concurrent strobe, then full 0xA5
    send(9'h007, 3, 1'b0);
    check("pre_clr_cnt", {28'd0, lsb_cnt}, 32'd3);
    deser_clr = 1'b1; deser_en = 1'b1; sampled_bit = 1'b1;
    @(posedge clk); #1;
    deser_clr = 1'b0; deser_en = 1'b0;
    check("clr_cnt", {24'd0, lsb_cnt, msb_cnt}, 32'd0);
    check("clr_keeps_pdata", {16'd0, lsb_p_data, msb_p_data}, 32'h1E0F);
    exp_lsb.push_back(8'hA5); exp_msb.push_back(8'hA5);
    send(9'h0A5, 8, 1'b0);
    idle(2);

    // 6: back-to-back words, then reset mid-word
    exp_lsb.push_back(8'h3C); exp_msb.push_back(8'h3C);
    exp_lsb.push_back(8'hC3); exp_msb.push_back(8'hC3);
    send(9'h03C, 8, 1'b1);
    send(9'h0C3, 8, 1'b1);
    send(9'h00F, 4, 1'b1);
    check("b2b_spacing", lsb_last_done_cyc - lsb_prev_done_cyc, 32'd8);
    check("third_word_cnt", {24'd0, lsb_cnt, msb_cnt}, 32'h44);
    rst = 1'b0;
    #1;
    check("async_rst_pdata", {16'd0, lsb_p_data, msb_p_data}, 32'd0);
    check("async_rst_cnt", {24'd0, lsb_cnt, msb_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(5);
    check("after_rst_pdata", {16'd0, lsb_p_data, msb_p_data}, 32'd0);

    check("lsb_queue_drained", exp_lsb.size(), 32'd0);
    check("msb_queue_drained", exp_msb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
